// File: rtl/output_controler.sv
// Per-output-port switch allocator: round-robin arbitration over input requests that target
// PORT_ID, a one-entry output holding register, and a forwarded-flit counter.
module output_controler #(
  parameter int unsigned            DATA_WIDTH = 8,
  parameter int unsigned            N_REGISTER = 3,
  parameter int unsigned            N_INPUT    = 5,
  parameter logic [N_REGISTER-1:0]  PORT_ID    = '0,
  parameter int unsigned            CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_INPUT*DATA_WIDTH-1:0]   Data_in,
  input  logic [N_INPUT*N_REGISTER-1:0]   register_in,
  input  logic                            full,
  output logic [N_INPUT-1:0]              s_ack,
  output logic [DATA_WIDTH-1:0]           Data_out,
  output logic                            write,
  output logic [CNT_WIDTH-1:0]            flit_cnt
);

  localparam int unsigned PtrW = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;

  typedef enum logic {StEmpty = 1'b0, StLoaded = 1'b1} state_e;

  state_e                r_state, w_state_next;
  logic [DATA_WIDTH-1:0] r_hold_data, w_hold_data_next;
  logic [PtrW-1:0]       r_rr_ptr, w_rr_ptr_next;
  logic [CNT_WIDTH-1:0]  r_flit_cnt, w_flit_cnt_next;

  logic [N_INPUT-1:0]    w_req;
  logic [DATA_WIDTH-1:0] w_data_arr [N_INPUT];
  logic [PtrW:0]         w_sum;
  logic [PtrW-1:0]       w_idx, w_gnt;
  logic                  w_hold_valid, w_cap_ok, w_found, w_grant, w_write;

  always_comb begin
    for (int unsigned i = 0; i < N_INPUT; i++) begin
      w_req[i]      = (register_in[i*N_REGISTER +: N_REGISTER] == PORT_ID);
      w_data_arr[i] = Data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Scan requests starting at the pointer, wrapping past the last input.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < N_INPUT; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (PtrW+1)'(k);
      if (w_sum >= (PtrW+1)'(N_INPUT)) begin
        w_sum = w_sum - (PtrW+1)'(N_INPUT);
      end
      w_idx = w_sum[PtrW-1:0];
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end

  assign w_hold_valid = (r_state == StLoaded);
  assign w_write      = w_hold_valid && !full;
  assign w_cap_ok     = !w_hold_valid || !full;
  // Grants are suppressed in reset so no input FIFO is popped for a flit that gets discarded.
  assign w_grant      = rst && w_found && w_cap_ok;

  always_comb begin
    s_ack = '0;
    if (w_grant) begin
      s_ack[w_gnt] = 1'b1;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_hold_data_next = r_hold_data;
    w_rr_ptr_next    = r_rr_ptr;
    w_flit_cnt_next  = r_flit_cnt;

    case (r_state)
      StEmpty: begin
        if (w_grant) w_state_next = StLoaded;
      end
      StLoaded: begin
        if (w_write && !w_grant) w_state_next = StEmpty;
      end
      default: w_state_next = StEmpty;
    endcase

    if (w_grant) begin
      w_hold_data_next = w_data_arr[w_gnt];
      w_rr_ptr_next    = (w_gnt == PtrW'(N_INPUT - 1)) ? '0 : w_gnt + PtrW'(1);
    end

    if (w_write) begin
      w_flit_cnt_next = r_flit_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= StEmpty;
      r_hold_data <= '0;
      r_rr_ptr    <= '0;
      r_flit_cnt  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_hold_data <= w_hold_data_next;
      r_rr_ptr    <= w_rr_ptr_next;
      r_flit_cnt  <= w_flit_cnt_next;
    end
  end

  assign Data_out = r_hold_data;
  assign write    = w_write;
  assign flit_cnt = r_flit_cnt;

endmodule

// File: tb/tb_output_controler.sv
// Directed bench for output_controler serving port E (001) with a 4-bit flit counter.
module tb_output_controler;

  localparam int DW = 8;
  localparam int NR = 3;
  localparam int NI = 5;
  localparam int CW = 4;

  logic              clk;
  logic              rst;
  logic [NI*DW-1:0]  data_in;
  logic [NI*NR-1:0]  reg_in;
  logic              full;
  logic [NI-1:0]     s_ack;
  logic [DW-1:0]     data_out;
  logic              write;
  logic [CW-1:0]     flit_cnt;

  logic [DW-1:0]     tb_data [NI];
  logic [NR-1:0]     tb_code [NI];

  int errors = 0;
  int checks = 0;

  output_controler #(
    .DATA_WIDTH(DW),
    .N_REGISTER(NR),
    .N_INPUT   (NI),
    .PORT_ID   (3'b001),
    .CNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Data_in    (data_in),
    .register_in(reg_in),
    .full       (full),
    .s_ack      (s_ack),
    .Data_out   (data_out),
    .write      (write),
    .flit_cnt   (flit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    data_in = '0;
    reg_in  = '0;
    for (int i = 0; i < NI; i++) begin
      data_in[i*DW +: DW] = tb_data[i];
      reg_in[i*NR +: NR]  = tb_code[i];
    end
  end

  // Returns just after a rising edge with reset released and no requests pending.
  task automatic apply_reset();
    @(posedge clk); #1;
    rst  = 1'b0;
    full = 1'b0;
    for (int i = 0; i < NI; i++) begin
      tb_code[i] = 3'b111;
      tb_data[i] = '0;
    end
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst  = 1'b0;
    full = 1'b0;
    for (int i = 0; i < NI; i++) begin
      tb_code[i] = 3'b001;
      tb_data[i] = 8'h10 + 8'(i);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (s_ack !== 5'b00000) begin
        errors++; $display("FAIL reset_ack c%0d: got %b want 00000", c, s_ack);
      end
      if (c > 0) begin
        checks++;
        if (write !== 1'b0 || data_out !== 8'h00 || flit_cnt !== 4'd0) begin
          errors++;
          $display("FAIL reset_state c%0d: got w=%b d=%h cnt=%0d want w=0 d=00 cnt=0",
                   c, write, data_out, flit_cnt);
        end
      end
      if (c < 2) @(posedge clk);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ack !== 5'b00001) begin
      errors++; $display("FAIL reset_first_ack: got %b want 00001", s_ack);
    end
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) tb_code[i] = 3'b111;
    @(negedge clk);
    checks++;
    if (write !== 1'b1 || data_out !== 8'h10 || s_ack !== 5'b00000) begin
      errors++;
      $display("FAIL reset_first_write: got w=%b d=%h ack=%b want w=1 d=10 ack=00000",
               write, data_out, s_ack);
    end
    @(negedge clk);
    checks++;
    if (write !== 1'b0 || flit_cnt !== 4'd1) begin
      errors++; $display("FAIL reset_cnt: got w=%b cnt=%0d want w=0 cnt=1", write, flit_cnt);
    end
  endtask

  task automatic test_single();
    apply_reset();
    tb_code[3] = 3'b001;
    tb_data[3] = 8'h0D;
    @(negedge clk);
    checks++;
    if (s_ack !== 5'b01000 || write !== 1'b0) begin
      errors++; $display("FAIL single_ack: got ack=%b w=%b want 01000 w=0", s_ack, write);
    end
    @(posedge clk); #1;
    tb_code[3] = 3'b111;
    @(negedge clk);
    checks++;
    if (write !== 1'b1 || data_out !== 8'h0D) begin
      errors++; $display("FAIL single_write: got w=%b d=%h want w=1 d=0d", write, data_out);
    end
    @(negedge clk);
    checks++;
    if (flit_cnt !== 4'd1 || write !== 1'b0) begin
      errors++; $display("FAIL single_cnt: got cnt=%0d w=%b want 1 w=0", flit_cnt, write);
    end
  endtask

  task automatic test_round_robin();
    logic [NI-1:0] exp_ack [6];
    logic [DW-1:0] exp_dat [6];
    exp_ack = '{5'b00010, 5'b00100, 5'b10000, 5'b00010, 5'b00100, 5'b10000};
    exp_dat = '{8'hA1, 8'hA2, 8'hA4, 8'hA1, 8'hA2, 8'hA4};
    apply_reset();
    tb_code[1] = 3'b001; tb_data[1] = 8'hA1;
    tb_code[2] = 3'b001; tb_data[2] = 8'hA2;
    tb_code[4] = 3'b001; tb_data[4] = 8'hA4;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      checks++;
      if (s_ack !== exp_ack[k]) begin
        errors++; $display("FAIL rr_ack k%0d: got %b want %b", k, s_ack, exp_ack[k]);
      end
      if (k > 0) begin
        checks++;
        if (write !== 1'b1 || data_out !== exp_dat[k-1]) begin
          errors++;
          $display("FAIL rr_write k%0d: got w=%b d=%h want w=1 d=%h",
                   k, write, data_out, exp_dat[k-1]);
        end
      end
    end
    @(posedge clk); #1;
    tb_code[1] = 3'b111; tb_code[2] = 3'b111; tb_code[4] = 3'b111;
    @(negedge clk);
    checks++;
    if (write !== 1'b1 || data_out !== 8'hA4) begin
      errors++; $display("FAIL rr_last: got w=%b d=%h want w=1 d=a4", write, data_out);
    end
    @(negedge clk);
    checks++;
    if (flit_cnt !== 4'd6) begin
      errors++; $display("FAIL rr_cnt: got %0d want 6", flit_cnt);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    tb_code[0] = 3'b001;
    tb_data[0] = 8'hA5;
    @(negedge clk);
    checks++;
    if (s_ack !== 5'b00001) begin
      errors++; $display("FAIL bp_load: got %b want 00001", s_ack);
    end
    @(posedge clk); #1;
    full       = 1'b1;
    tb_data[0] = 8'h5A;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      checks++;
      if (write !== 1'b0 || data_out !== 8'hA5 || s_ack !== 5'b00000) begin
        errors++;
        $display("FAIL bp_stall c%0d: got w=%b d=%h ack=%b want w=0 d=a5 ack=00000",
                 c, write, data_out, s_ack);
      end
    end
    @(posedge clk); #1;
    full = 1'b0;
    @(negedge clk);
    checks++;
    if (write !== 1'b1 || data_out !== 8'hA5 || s_ack !== 5'b00001) begin
      errors++;
      $display("FAIL bp_release: got w=%b d=%h ack=%b want w=1 d=a5 ack=00001",
               write, data_out, s_ack);
    end
    @(posedge clk); #1;
    tb_code[0] = 3'b111;
    @(negedge clk);
    checks++;
    if (write !== 1'b1 || data_out !== 8'h5A || s_ack !== 5'b00000) begin
      errors++;
      $display("FAIL bp_next: got w=%b d=%h ack=%b want w=1 d=5a ack=00000",
               write, data_out, s_ack);
    end
    @(negedge clk);
    checks++;
    if (write !== 1'b0 || flit_cnt !== 4'd2) begin
      errors++; $display("FAIL bp_cnt: got w=%b cnt=%0d want w=0 cnt=2", write, flit_cnt);
    end
  endtask

  task automatic test_non_matching();
    apply_reset();
    tb_code[0] = 3'b010; tb_code[1] = 3'b111; tb_code[2] = 3'b101;
    tb_code[3] = 3'b011; tb_code[4] = 3'b000;
    for (int i = 0; i < NI; i++) tb_data[i] = 8'hC0 + 8'(i);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      checks++;
      if (s_ack !== 5'b00000 || write !== 1'b0) begin
        errors++;
        $display("FAIL nomatch c%0d: got ack=%b w=%b want 00000 w=0", c, s_ack, write);
      end
    end
    checks++;
    if (flit_cnt !== 4'd0 || data_out !== 8'h00) begin
      errors++; $display("FAIL nomatch_state: got cnt=%0d d=%h want 0 00", flit_cnt, data_out);
    end
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    tb_code[2] = 3'b001;
    tb_data[2] = 8'h77;
    for (int c = 0; c < 17; c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      checks++;
      if (s_ack !== 5'b00100) begin
        errors++; $display("FAIL wrap_ack c%0d: got %b want 00100", c, s_ack);
      end
    end
    @(posedge clk); #1;
    tb_code[2] = 3'b111;
    @(negedge clk);
    checks++;
    if (write !== 1'b1 || flit_cnt !== 4'd0) begin
      errors++; $display("FAIL wrap_pre: got w=%b cnt=%0d want w=1 cnt=0", write, flit_cnt);
    end
    @(negedge clk);
    checks++;
    if (write !== 1'b0 || flit_cnt !== 4'd1) begin
      errors++; $display("FAIL wrap_cnt: got w=%b cnt=%0d want w=0 cnt=1", write, flit_cnt);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    full       = 1'b1;
    tb_code[0] = 3'b001;
    tb_data[0] = 8'h3C;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ack !== 5'b00000 || data_out !== 8'h3C) begin
      errors++;
      $display("FAIL midrst_ack: got ack=%b d=%h want 00000 d=3c", s_ack, data_out);
    end
    @(posedge clk); #1;
    rst        = 1'b1;
    full       = 1'b0;
    tb_code[0] = 3'b111;
    @(negedge clk);
    checks++;
    if (write !== 1'b0 || data_out !== 8'h00) begin
      errors++; $display("FAIL midrst_drop: got w=%b d=%h want w=0 d=00", write, data_out);
    end
  endtask

  initial begin
    rst  = 1'b1;
    full = 1'b0;
    for (int i = 0; i < NI; i++) begin
      tb_code[i] = 3'b111;
      tb_data[i] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_non_matching();
    test_counter_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_controler.md
# output_controler

Per-output-port switch allocator and output stage of the NoC router; one instance sits on each of the five router output ports (local, E, W, N, S). It collects routing requests from the five input controllers as data-plus-route-code pairs. It arbitrates among requests aimed at its own port using round-robin, and returns `s_ack` to the winner so the winner pops its input FIFO. The granted flit is buffered in a one-entry output register and written into the downstream FIFO (neighbour router or local core) when that FIFO is not full.

## Interface
- `DATA_WIDTH`, 8, flit width; bits [1:0] hold X destination, [3:2] hold Y destination; the flit is not modified by this block.
- `N_REGISTER`, 3, width of a route code.
- `N_INPUT`, 5, number of input controllers; index 0=local, 1=E, 2=W, 3=N, 4=S.
- `PORT_ID`, 3'b000, route code this instance serves (000 local, 001 E, 010 W, 011 N, 100 S).
- `CNT_WIDTH`, 16, width of the forwarded-flit counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `Data_in`  in  N_INPUT*DATA_WIDTH  flit from input controller i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `register_in`  in  N_INPUT*N_REGISTER  route code from input controller i at bits [i*N_REGISTER +: N_REGISTER]; 3'b111 means no request.
- `full`  in  1  downstream FIFO full.
- `s_ack`  out  N_INPUT  one-hot grant back to input controllers; at most one bit high.
- `Data_out`  out  DATA_WIDTH  flit presented to downstream FIFO.
- `write`  out  1  downstream FIFO write strobe.
- `flit_cnt`  out  CNT_WIDTH  number of flits written downstream.

## Operation
- Request: `req[i] = (register_in[i] == PORT_ID)`. Codes 101, 110, 111, or any other port ID never request.
- State: holding register `hold_data`, flag `hold_valid`, round-robin pointer `rr_ptr` (0..N_INPUT-1), `flit_cnt`.
- Two-state FSM on `hold_valid`: EMPTY (0) and LOADED (1).
- Capture permitted (`cap_ok`) when `!hold_valid || !full`, i.e. the holding entry is empty or drains this cycle.
- Arbitration (combinational): search req starting at `rr_ptr`, ascending, wrapping N_INPUT-1→0; the first hit is `gnt`. If there is no request, or `cap_ok`=0, `s_ack`=0.
- `s_ack[gnt]`=1 in the same cycle the winner's `Data_in` is loaded into `hold_data` at the next edge. `hold_valid` is then set.
- `rr_ptr` becomes `gnt+1` (wrapping to 0 after N_INPUT-1) only on a grant. Otherwise it holds.
- `write = hold_valid && !full`; `Data_out = hold_data`.
- A write without a capture clears `hold_valid`. A write with a capture in the same cycle keeps `hold_valid`=1 with the new flit (back-to-back, one flit per cycle).
- `flit_cnt` increments by 1 on every cycle with `write`=1 and wraps modulo 2^CNT_WIDTH.
- Transitions: EMPTY→LOADED on a grant. LOADED→EMPTY on write with no grant. LOADED→LOADED on write with a grant, or when `full`=1 (stall: data held, no grant).

## Timing
- Reset (`rst`=0 at an edge): `hold_valid`=0, `hold_data`=0, `rr_ptr`=0, `flit_cnt`=0. Consequently `Data_out`=0, `write`=0, and `s_ack`=0 throughout reset cycles regardless of requests.
- Reset mid-operation discards any held flit. The input controller's FIFO is not popped for it, because `s_ack` is forced low.
- Latency: request visible at cycle t → `s_ack` at t (if `cap_ok`) → `write` with that flit at t+1 (if `full`=0 at t+1).
- Throughput: 1 flit/cycle while requests persist and `full`=0.
- `full` rising while LOADED: `write`=0, data stable, no new `s_ack` until `full` falls.
- Simultaneous requests: only the grantee sees `s_ack`. The others keep their request and are served in rotation, so any continuous requester is granted within N_INPUT grants.
- A request withdrawn (code changes) in a cycle without a grant is simply dropped from arbitration; there is no state to clean.

## Test plan
- Reset: hold `rst`=0 for 3 cycles while all five inputs request PORT_ID → `s_ack`=0, `write`=0, `Data_out`=0, `flit_cnt`=0; release → `s_ack`=5'b00001 on the first active cycle, `write`=1 with input 0's flit next cycle.
- Single request: PORT_ID=001, input 3 sends flit 8'h0D with code 001, `full`=0 → `s_ack`=5'b01000 at t, `Data_out`=8'h0D and `write`=1 at t+1, `flit_cnt`=1.
- Round-robin: inputs 1, 2 and 4 request continuously → grant order 1, 2, 4, 1, 2, 4 on consecutive cycles; `write` high every cycle after the first.
- Backpressure: LOADED with 8'hA5, assert `full` for 4 cycles with input 0 requesting → `write`=0, `Data_out`=8'hA5, `s_ack`=0 for 4 cycles; `full` falls → `write`=1 and `s_ack`=5'b00001 in the same cycle.
- Non-matching codes: inputs send codes 010, 111 and 101 with PORT_ID=001 → `s_ack`=0 and `write`=0 forever.
- Counter wrap: CNT_WIDTH=4, 17 flits forwarded → `flit_cnt` reads 1.
